mips_dmem_mmio: RTL

- Data-memory stage directly downstream of the single-cycle MIPS core.
- Consumes the core's memwrite, aluout (address) and writedata; returns readdata in the same cycle.
- Decodes the address into a word RAM region and a peripheral region.
- The peripheral region holds a compare/match timer and a byte-wide TX FIFO with a valid/ready output handshake for a character sink (UART or testbench).

---
 rtl/mips_dmem_mmio.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mips_dmem_mmio.sv
// Data memory for the single-cycle MIPS core: word RAM plus a timer and a TX byte FIFO.
// Optional irq output and TCTRL irq-enable bit are built when MMIO_IRQ_EN is defined.
module mips_dmem_mmio #(
  parameter int unsigned RAM_AW   = 6,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef MMIO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;
`ifdef MMIO_IRQ_EN
  localparam logic [2:0] CtrlMask = 3'b111;
`else
  localparam logic [2:0] CtrlMask = 3'b011;
`endif

  logic [31:0] ram [2**RAM_AW];

  logic [31:0]   tcount, tcmp;
  logic [2:0]    tctrl;
  logic          match, ovf;
  logic [7:0]    fifo [TX_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic       ram_sel, per_sel, per_we, hit;
  logic [5:0] off;
  logic       full, empty, push, pop, accept, drop;
  logic       clr_match, clr_ovf;
  logic       unused_addr;

  assign unused_addr = ^addr[1:0];

  always_comb begin
    ram_sel   = ~addr[31];
    per_sel   = (addr[31:8] == 24'hFFFFFF);
    off       = addr[7:2];
    per_we    = memwrite & per_sel;
    hit       = tctrl[0] & (tcount == tcmp);
    full      = (count == CW'(TX_DEPTH));
    empty     = (count == '0);
    pop       = ~empty & tx_ready;
    push      = per_we & (off == 6'h04);
    accept    = push & (~full | pop);
    drop      = push & full & ~pop;
    clr_match = per_we & (off == 6'h03) & writedata[0];
    clr_ovf   = per_we & (off == 6'h03) & writedata[3];
  end

  assign tx_valid = ~empty;
  assign tx_data  = fifo[rd_ptr];

  // RAM is intentionally not reset.
  always_ff @(posedge clk) begin
    if (memwrite && ram_sel) ram[addr[RAM_AW+1:2]] <= writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcount <= '0;
      tcmp   <= '0;
      tctrl  <= '0;
      match  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      // Software write to TCOUNT beats both increment and reload.
      if (per_we && off == 6'h00) tcount <= writedata;
      else if (tctrl[0])          tcount <= (hit && tctrl[1]) ? '0 : tcount + 32'd1;
      if (per_we && off == 6'h01) tcmp <= writedata;
      if (per_we && off == 6'h02) tctrl <= writedata[2:0] & CtrlMask;
      match <= hit | (match & ~clr_match);
      ovf   <= drop | (ovf & ~clr_ovf);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(TX_DEPTH); i++) fifo[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        fifo[wr_ptr] <= writedata[7:0];
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(pop);
    end
  end

`ifdef MMIO_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= match & tctrl[2];
  end
`endif

  always_comb begin
    readdata = '0;
    if (ram_sel) begin
      readdata = ram[addr[RAM_AW+1:2]];
    end else if (per_sel) begin
      case (off)
        6'h00:   readdata = tcount;
        6'h01:   readdata = tcmp;
        6'h02:   readdata = {29'b0, tctrl};
        6'h03:   readdata = {28'b0, ovf, empty, full, match};
        6'h04:   readdata = {{(32-CW){1'b0}}, count};
        default: readdata = '0;
      endcase
    end
  end

endmodule
